mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Parametrised N-channel front-end arbiter between CPU-side memory requesters (instruction fetch, load/store, future prefetch) and the single-outstanding MemoryController. It latches one winning request, drives it to the controller until completion, and returns the result to the winner through a per-channel valid/ready handshake. It adds fixed or round-robin priority, a channel count beyond two, and per-channel cancel with drain of an in-flight read.

## Interface
- NCH, 2, number of requester channels (≥2); channel 0 highest fixed priority
- AW, 32, address width
- DW, 32, data width
- clk_in  in  1  system clock
- rst_in  in  1  reset, asynchronous, active-high
- rdy_in  in  1  global enable; low freezes all state
- req_valid  in  NCH  per-channel request
- req_wr  in  NCH  1 = write
- req_size  in  2*NCH  0 byte, 1 half, 2 word (3 illegal, treated as word)
- req_addr  in  AW*NCH  per-channel address
- req_data  in  DW*NCH  per-channel write data
- req_cancel  in  NCH  abandon this channel's pending read
- req_ready  out  NCH  one-cycle completion pulse, granted channel only
- res  out  DW  completion data (mc_res passthrough)
- grant_id  out  $clog2(NCH)  channel currently owning the controller
- mc_valid  out  1  request to MemoryController
- mc_wr, mc_addr, mc_len, mc_data  out  1/AW/2/DW  muxed from grant_id
- mc_ready  in  1  controller completion
- mc_res  in  DW  controller result

## Operation
- States: IDLE, BUSY, DRAIN.
- IDLE: if any req_valid, pick winner, latch grant_id, mc_valid←1, →BUSY. No request: stay.
- BUSY: mc_* driven from channel grant_id; requester holds its fields stable while req_valid high. On mc_ready: req_ready[grant_id]=1 (combinational, same cycle), res=mc_res, mc_valid←0, →IDLE.
- Cancel: req_cancel[grant_id] in BUSY with req_wr=0 → DRAIN. Writes ignore cancel and always complete. Cancel of a non-granted channel has no effect on the arbiter.
- DRAIN: mc_valid stays 1 (the controller cannot abort); on mc_ready: no req_ready pulse, mc_valid←0, →IDLE.
- Cancel and mc_ready in the same BUSY cycle: req_ready suppressed, →IDLE.
- Requester drops req_valid at the edge where it samples req_ready.
- rdy_in low: state, grant and pointer held; req_ready forced 0.
- Reset values: state IDLE, mc_valid 0, grant_id 0, req_ready 0, rr_last NCH-1.

## Timing
- Request visible in IDLE at edge k → mc_valid=1 from cycle k+1.
- Completion: req_ready in the same cycle as mc_ready; back in IDLE at the next cycle.
- One idle bubble between consecutive transactions: ≥1 IDLE cycle. Next grant at the earliest one cycle after ready.
- Total latency = 1 + controller latency + 1 bubble.
- Reset mid-transaction: immediate IDLE, mc_valid 0. The controller is reset by the same rst_in.

## Configuration
- MEM_ARB_RR_EN defined: round-robin. Search starts at (rr_last+1) mod NCH; rr_last←grant_id at each grant, including cancelled grants.
- Undefined: fixed priority, lowest index wins. rr_last is not implemented.

## Structure
- Package mem_arb_pkg: state encoding (IDLE/BUSY/DRAIN), size constants SZ_BYTE/SZ_HALF/SZ_WORD.
- Sub-module arb_pick: combinational NCH-wide selector with request vector and start index in, one-hot plus encoded winner out. Fixed priority is the start=0 case.

## Test plan
- NCH=2, ch0 read 0x100 and ch1 read 0x200 both raised in IDLE, controller 3-cycle latency → ch0 granted first, req_ready[0] with res=mem[0x100], ch1 completes after one bubble.
- MEM_ARB_RR_EN, NCH=3, all channels requesting continuously → grant order 0,1,2,0; without the macro → 0 every time.
- ch1 read granted, req_cancel[1] pulsed two cycles later → mc_valid held until mc_ready, no req_ready[1], then IDLE.
- ch0 write 0x12345678 to 0x40 with req_cancel[0] asserted → write completes, req_ready[0] pulses, memory updated.
- Cancel asserted in the same cycle as mc_ready → no req_ready pulse, IDLE next cycle.
- rdy_in low for 4 cycles mid-BUSY, then rst_in asserted async mid-BUSY → state frozen during pause; reset gives mc_valid=0, grant_id=0 immediately.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory front-end arbiter: FSM state
// encoding, access-size codes and a size normalisation helper.
// Build option: MEM_ARB_RR_EN selects round-robin arbitration in mem_arbiter.
package mem_arb_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Size code 3 is illegal; the controller sees it as a word access.
  function automatic logic [1:0] norm_size(input logic [1:0] sz);
    return (sz == 2'd3) ? SZ_WORD : sz;
  endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational rotating-priority selector. The search begins at index
// 'start' and wraps; the first requesting channel found wins. A start of
// zero gives plain fixed priority (lowest index wins).
module arb_pick #(
  parameter int NCH = 2,
  parameter int IW  = $clog2(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [IW-1:0]  start,
  output logic [NCH-1:0] onehot,
  output logic [IW-1:0]  winner
);

  // Walk offsets from the far end back to the start so the closest
  // requester (smallest offset from start) is the last one written.
  always_comb begin
    int idx;
    idx    = 0;
    onehot = '0;
    winner = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      idx = (int'(start) + i) % NCH;
      if (req[idx]) begin
        onehot      = '0;
        onehot[idx] = 1'b1;
        winner      = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// N-channel arbiter in front of a single-outstanding memory controller.
// Latches one winner, forwards its request until mc_ready, and returns the
// result with a one-cycle req_ready pulse. A cancelled read is drained
// (controller still completes it) without notifying the requester.
// Build option: MEM_ARB_RR_EN enables round-robin; otherwise fixed priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NCH = 2,
  parameter int AW  = 32,
  parameter int DW  = 32
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic [NCH-1:0]          req_valid,
  input  logic [NCH-1:0]          req_wr,
  input  logic [2*NCH-1:0]        req_size,
  input  logic [AW*NCH-1:0]       req_addr,
  input  logic [DW*NCH-1:0]       req_data,
  input  logic [NCH-1:0]          req_cancel,
  output logic [NCH-1:0]          req_ready,
  output logic [DW-1:0]           res,
  output logic [$clog2(NCH)-1:0]  grant_id,
  output logic                    mc_valid,
  output logic                    mc_wr,
  output logic [AW-1:0]           mc_addr,
  output logic [1:0]              mc_len,
  output logic [DW-1:0]           mc_data,
  input  logic                    mc_ready,
  input  logic [DW-1:0]           mc_res
);

  localparam int IW = $clog2(NCH);

  logic [1:0]     state_reg;
  logic [IW-1:0]  grant_reg;
  logic           mc_valid_reg;

  logic [AW-1:0]  addr_arr [NCH];
  logic [DW-1:0]  data_arr [NCH];
  logic [1:0]     size_arr [NCH];

  logic [NCH-1:0] pick_onehot;
  logic [IW-1:0]  pick_winner;
  logic           pick_any;
  logic [IW-1:0]  pick_start;

  logic           cancel_read;
  logic           done_pulse;

  // Split the flat per-channel buses into indexable arrays and build the
  // per-channel completion pulse.
  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_chan
      assign addr_arr[gi]  = req_addr[gi*AW +: AW];
      assign data_arr[gi]  = req_data[gi*DW +: DW];
      assign size_arr[gi]  = norm_size(req_size[2*gi +: 2]);
      assign req_ready[gi] = done_pulse && (grant_reg == IW'(gi));
    end
  endgenerate

`ifdef MEM_ARB_RR_EN
  logic [IW-1:0] rr_last_reg;

  // Search begins one past the most recent grant, wrapping at NCH.
  assign pick_start = (rr_last_reg == IW'(NCH - 1)) ? '0 : rr_last_reg + 1'b1;

  // Remember every grant (cancelled ones included) for rotation.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)
      rr_last_reg <= IW'(NCH - 1);
    else if (rdy_in && state_reg == ST_IDLE && pick_any)
      rr_last_reg <= pick_winner;
  end
`else
  assign pick_start = '0;
`endif

  arb_pick #(.NCH(NCH), .IW(IW)) u_pick (
    .req    (req_valid),
    .start  (pick_start),
    .onehot (pick_onehot),
    .winner (pick_winner)
  );

  assign pick_any = |pick_onehot;

  // A cancel only matters for the granted channel and only for reads.
  assign cancel_read = req_cancel[grant_reg] && !req_wr[grant_reg];
  assign done_pulse  = rdy_in && (state_reg == ST_BUSY) && mc_ready && !cancel_read;

  // Main FSM: grant in IDLE, wait for completion in BUSY/DRAIN.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_reg    <= ST_IDLE;
      grant_reg    <= '0;
      mc_valid_reg <= 1'b0;
    end else if (rdy_in) begin
      case (state_reg)
        ST_IDLE: begin
          if (pick_any) begin
            grant_reg    <= pick_winner;
            mc_valid_reg <= 1'b1;
            state_reg    <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (mc_ready) begin
            mc_valid_reg <= 1'b0;
            state_reg    <= ST_IDLE;
          end else if (cancel_read) begin
            state_reg    <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (mc_ready) begin
            mc_valid_reg <= 1'b0;
            state_reg    <= ST_IDLE;
          end
        end
        default: begin
          mc_valid_reg <= 1'b0;
          state_reg    <= ST_IDLE;
        end
      endcase
    end
  end

  assign grant_id = grant_reg;
  assign mc_valid = mc_valid_reg;
  assign mc_wr    = req_wr[grant_reg];
  assign mc_addr  = addr_arr[grant_reg];
  assign mc_len   = size_arr[grant_reg];
  assign mc_data  = data_arr[grant_reg];
  assign res      = mc_res;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with three channels; the bench plays the
// role of the memory controller by driving mc_ready/mc_res by hand.
// Expected grant order follows MEM_ARB_RR_EN when it is defined.
module tb_mem_arbiter;

  localparam int NCH = 3;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int IW  = $clog2(NCH);

  logic                 clk_in = 1'b0;
  logic                 rst_in;
  logic                 rdy_in;
  logic [NCH-1:0]       req_valid;
  logic [NCH-1:0]       req_wr;
  logic [2*NCH-1:0]     req_size;
  logic [AW*NCH-1:0]    req_addr;
  logic [DW*NCH-1:0]    req_data;
  logic [NCH-1:0]       req_cancel;
  logic [NCH-1:0]       req_ready;
  logic [DW-1:0]        res;
  logic [IW-1:0]        grant_id;
  logic                 mc_valid;
  logic                 mc_wr;
  logic [AW-1:0]        mc_addr;
  logic [1:0]           mc_len;
  logic [DW-1:0]        mc_data;
  logic                 mc_ready;
  logic [DW-1:0]        mc_res;

  logic [31:0] mem [0:255];
  int n_cmp = 0;
  int n_err = 0;
  int exp_order [4];

  mem_arbiter #(.NCH(NCH), .AW(AW), .DW(DW)) dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .rdy_in     (rdy_in),
    .req_valid  (req_valid),
    .req_wr     (req_wr),
    .req_size   (req_size),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .req_cancel (req_cancel),
    .req_ready  (req_ready),
    .res        (res),
    .grant_id   (grant_id),
    .mc_valid   (mc_valid),
    .mc_wr      (mc_wr),
    .mc_addr    (mc_addr),
    .mc_len     (mc_len),
    .mc_data    (mc_data),
    .mc_ready   (mc_ready),
    .mc_res     (mc_res)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_chan(input int ch, input logic wr, input logic [1:0] sz,
                          input logic [31:0] addr, input logic [31:0] data);
    req_wr[ch]             = wr;
    req_size[2*ch +: 2]    = sz;
    req_addr[AW*ch +: AW]  = addr;
    req_data[DW*ch +: DW]  = data;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 + i;
`ifdef MEM_ARB_RR_EN
    exp_order = '{0, 1, 2, 0};
`else
    exp_order = '{0, 0, 0, 0};
`endif
    rst_in = 1'b1; rdy_in = 1'b1; req_valid = '0; req_wr = '0; req_size = '0;
    req_addr = '0; req_data = '0; req_cancel = '0; mc_ready = 1'b0; mc_res = '0;

    // Reset state
    #2;
    chk("rst_mc_valid", 64'(mc_valid), 64'd0);
    chk("rst_grant", 64'(grant_id), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    #10; rst_in = 1'b0;
    tick();

    // Two simultaneous reads: ch0 first, ch1 after one bubble, latency 3
    set_chan(0, 1'b0, 2'd2, 32'h100, 32'h0);
    set_chan(1, 1'b0, 2'd3, 32'h200, 32'h0);
    req_valid = 3'b011;
    #1; chk("t1_idle_no_valid", 64'(mc_valid), 64'd0);
    tick();
    chk("t1_mc_valid", 64'(mc_valid), 64'd1);
    chk("t1_grant0", 64'(grant_id), 64'd0);
    chk("t1_addr0", 64'(mc_addr), 64'h100);
    chk("t1_wr0", 64'(mc_wr), 64'd0);
    tick(); tick();
    chk("t1_wait_ready", 64'(req_ready), 64'd0);
    mc_ready = 1'b1; mc_res = mem[32'h100 >> 2];
    #1;
    chk("t1_ready0", 64'(req_ready), 64'b001);
    chk("t1_res0", 64'(res), 64'hA500_0040);
    tick(); mc_ready = 1'b0; req_valid[0] = 1'b0;
    chk("t1_bubble", 64'(mc_valid), 64'd0);
    tick();
    chk("t1_grant1", 64'(grant_id), 64'd1);
    chk("t1_addr1", 64'(mc_addr), 64'h200);
    chk("t1_len_illegal", 64'(mc_len), 64'd2);
    tick(); tick();
    mc_ready = 1'b1; mc_res = mem[32'h200 >> 2];
    #1;
    chk("t1_ready1", 64'(req_ready), 64'b010);
    chk("t1_res1", 64'(res), 64'hA500_0080);
    tick(); mc_ready = 1'b0; req_valid = '0;
    chk("t1_end_idle", 64'(mc_valid), 64'd0);

    // Continuous requests from all channels: grant sequence
    rst_in = 1'b1; #1; rst_in = 1'b0;
    set_chan(0, 1'b0, 2'd2, 32'h10, 32'h0);
    set_chan(1, 1'b0, 2'd2, 32'h20, 32'h0);
    set_chan(2, 1'b0, 2'd2, 32'h30, 32'h0);
    req_valid = 3'b111;
    for (int n = 0; n < 4; n++) begin
      tick();
      chk($sformatf("t2_grant_%0d", n), 64'(grant_id), 64'(exp_order[n]));
      mc_ready = 1'b1; mc_res = 32'(n);
      #1;
      chk($sformatf("t2_ready_%0d", n), 64'(req_ready), 64'(1) << exp_order[n]);
      tick(); mc_ready = 1'b0;
      chk($sformatf("t2_bubble_%0d", n), 64'(mc_valid), 64'd0);
    end
    req_valid = '0;

    // Cancel of granted read: drain without req_ready, no re-arbitration
    set_chan(1, 1'b0, 2'd2, 32'h200, 32'h0);
    req_valid = 3'b010;
    tick();
    chk("t3_grant1", 64'(grant_id), 64'd1);
    tick(); tick();
    req_cancel[1] = 1'b1;
    tick(); req_cancel = '0; req_valid = 3'b001;
    set_chan(0, 1'b0, 2'd2, 32'h100, 32'h0);
    chk("t3_drain_valid", 64'(mc_valid), 64'd1);
    tick();
    chk("t3_drain_hold", 64'(mc_valid), 64'd1);
    chk("t3_drain_grant", 64'(grant_id), 64'd1);
    mc_ready = 1'b1; mc_res = 32'hDEAD_BEEF;
    #1; chk("t3_no_ready", 64'(req_ready), 64'd0);
    tick(); mc_ready = 1'b0;
    chk("t3_idle", 64'(mc_valid), 64'd0);
    tick();
    chk("t3_next_grant", 64'(grant_id), 64'd0);
    chk("t3_next_valid", 64'(mc_valid), 64'd1);
    mc_ready = 1'b1; mc_res = mem[32'h100 >> 2];
    #1; chk("t3_next_ready", 64'(req_ready), 64'b001);
    tick(); mc_ready = 1'b0; req_valid = '0;

    // Write with cancel asserted still completes
    set_chan(0, 1'b1, 2'd2, 32'h40, 32'h1234_5678);
    req_cancel[0] = 1'b1; req_valid = 3'b001;
    tick();
    chk("t4_wr", 64'(mc_wr), 64'd1);
    chk("t4_addr", 64'(mc_addr), 64'h40);
    chk("t4_data", 64'(mc_data), 64'h1234_5678);
    tick();
    mc_ready = 1'b1;
    #1;
    chk("t4_ready", 64'(req_ready), 64'b001);
    if (mc_wr) mem[mc_addr[9:2]] = mc_data;
    tick(); mc_ready = 1'b0; req_valid = '0; req_cancel = '0; req_wr = '0;
    chk("t4_idle", 64'(mc_valid), 64'd0);
    chk("t4_mem", 64'(mem[32'h40 >> 2]), 64'h1234_5678);

    // Cancel in the same cycle as mc_ready
    set_chan(0, 1'b0, 2'd2, 32'h100, 32'h0);
    req_valid = 3'b001;
    tick();
    chk("t5_busy", 64'(mc_valid), 64'd1);
    req_cancel[0] = 1'b1; mc_ready = 1'b1;
    #1; chk("t5_no_ready", 64'(req_ready), 64'd0);
    tick(); mc_ready = 1'b0; req_cancel = '0; req_valid = 3'b010;
    chk("t5_idle", 64'(mc_valid), 64'd0);
    tick();
    chk("t5_regrant", 64'(grant_id), 64'd1);
    chk("t5_regrant_valid", 64'(mc_valid), 64'd1);

    // Pause mid-BUSY, then asynchronous reset mid-BUSY
    rdy_in = 1'b0; mc_ready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      tick();
      chk($sformatf("t6_pause_valid_%0d", n), 64'(mc_valid), 64'd1);
      chk($sformatf("t6_pause_grant_%0d", n), 64'(grant_id), 64'd1);
      chk($sformatf("t6_pause_ready_%0d", n), 64'(req_ready), 64'd0);
    end
    rdy_in = 1'b1; mc_ready = 1'b0;
    tick();
    chk("t6_resume_busy", 64'(mc_valid), 64'd1);
    #3; rst_in = 1'b1;
    #1;
    chk("t6_rst_valid", 64'(mc_valid), 64'd0);
    chk("t6_rst_grant", 64'(grant_id), 64'd0);
    chk("t6_rst_ready", 64'(req_ready), 64'd0);
    #1; rst_in = 1'b0; req_valid = '0;
    tick();
    chk("t6_after_rst", 64'(mc_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
